// File: rtl/execute_y_scheduler_if.sv
// Issue-request handshake from one requester into the Y scheduler.
// Transfer happens on a cycle where valid and ready are both high.
interface execute_y_scheduler_if;
  logic        valid;
  logic        ready;
  logic [31:0] rega;
  logic [31:0] regb;
  logic [4:0]  srca;
  logic [4:0]  srcb;
  logic [4:0]  regdest;

  modport master (
    output valid, rega, regb, srca, srcb, regdest,
    input  ready
  );

  modport slave (
    input  valid, rega, regb, srca, srcb, regdest,
    output ready
  );
endinterface

// File: rtl/execute_y_scheduler.sv
// Y (multiply) pipeline issue scheduler: two-way round-robin arbitration,
// RAW/WAW blocking on in-flight destinations and an outstanding-op cap.
module execute_y_scheduler #(
  parameter int LATENCY      = 4,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  execute_y_scheduler_if.slave        req0,
  execute_y_scheduler_if.slave        req1,
  output logic [1:0]                  is_y_functionalunit,
  output logic [31:0]                 is_y_rega,
  output logic [31:0]                 is_y_regb,
  output logic [4:0]                  is_y_regdest,
  output logic [31:0]                 y_busy_mask,
  output logic [2:0]                  y_inflight
);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
  } trk_t;

  trk_t [LATENCY-1:0] trk_q, trk_d;
  logic               iss_q, iss_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [4:0]         rd_q, rd_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               prio1_q, prio1_d;

  logic        retire;
  logic [2:0]  live;
  logic        cap_ok;
  logic [31:0] mask;
  logic        elig0, elig1;
  logic        g0, g1;

  function automatic logic hz(
    input logic [31:0] m,
    input logic [4:0]  r
  );
    return (r != 5'd0) && m[r];
  endfunction

  // Busy covers the op on the issue bus plus every tracked op, retiring included.
  always_comb begin
    mask = '0;
    if (iss_q) mask[rd_q] = 1'b1;
    for (int i = 0; i < LATENCY; i++) begin
      if (trk_q[i].v) mask[trk_q[i].rd] = 1'b1;
    end
    mask[0] = 1'b0;
  end

  assign retire = trk_q[LATENCY-1].v;
  assign live   = cnt_q - {2'b0, retire};
  assign cap_ok = live < 3'(MAX_INFLIGHT);

  assign elig0 = req0.valid && cap_ok
              && !hz(mask, req0.srca)
              && !hz(mask, req0.srcb)
              && !hz(mask, req0.regdest);

  assign elig1 = req1.valid && cap_ok
              && !hz(mask, req1.srca)
              && !hz(mask, req1.srcb)
              && !hz(mask, req1.regdest);

  assign g0 = elig0 && (!elig1 || !prio1_q);
  assign g1 = elig1 && (!elig0 ||  prio1_q);

  assign req0.ready = g0;
  assign req1.ready = g1;

  always_comb begin
    iss_d   = g0 | g1;
    a_d     = '0;
    b_d     = '0;
    rd_d    = '0;
    prio1_d = prio1_q;
    unique case (1'b1)
      g0: begin
        a_d     = req0.rega;
        b_d     = req0.regb;
        rd_d    = req0.regdest;
        prio1_d = 1'b1;
      end
      g1: begin
        a_d     = req1.rega;
        b_d     = req1.regb;
        rd_d    = req1.regdest;
        prio1_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Slot 0 captures the op while it sits on the issue bus.
  always_comb begin
    trk_d[0].v  = iss_q;
    trk_d[0].rd = iss_q ? rd_q : 5'd0;
    for (int i = 1; i < LATENCY; i++) begin
      trk_d[i] = trk_q[i-1];
    end
    cnt_d = cnt_q + {2'b0, iss_d} - {2'b0, retire};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trk_q   <= '0;
      iss_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      prio1_q <= 1'b0;
    end else begin
      trk_q   <= trk_d;
      iss_q   <= iss_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      prio1_q <= prio1_d;
    end
  end

  assign is_y_functionalunit = iss_q ? 2'd3 : 2'd0;
  assign is_y_rega           = a_q;
  assign is_y_regb           = b_q;
  assign is_y_regdest        = rd_q;
  assign y_busy_mask         = mask;
  assign y_inflight          = cnt_q;

endmodule
